// File: rtl/cache_bank_ram_pkg.sv
// Shared defaults and helpers for the cache way data array.
package cache_bank_ram_pkg;

  localparam int CB_DATA_LEN   = 4;
  localparam int CB_DATA_PACK  = 2;
  localparam int CB_DATA_WIDTH = 32;
  localparam int CB_W          = CB_DATA_PACK * CB_DATA_WIDTH;
  localparam int CB_DATA_NUM   = 64;
  localparam int CB_ADDR_WIDTH = 6;

  // Index of the lowest set bit; 0 when nothing is set (callers gate on |v).
  function automatic int lowest_set(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/cache_bank_ram_slice.sv
// One sub-block column of the data array: DATA_NUM beats, single write port,
// combinational read that returns zero for out-of-range indices.
module cache_bank_ram_slice
  import cache_bank_ram_pkg::*;
#(
  parameter int W          = CB_W,
  parameter int DATA_NUM   = CB_DATA_NUM,
  parameter int ADDR_WIDTH = CB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [W-1:0]          i_wdata,
  output logic [W-1:0]          o_rdata
);

  logic [W-1:0] r_mem [DATA_NUM];
  logic         w_in_range;

  assign w_in_range = (32'(i_addr) < 32'(DATA_NUM));

  // Contents are deliberately never reset, matching a hard macro.
  always_ff @(posedge clk) begin
    if (i_we && w_in_range) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = w_in_range ? r_mem[i_addr] : '0;

endmodule

// File: rtl/cache_bank_ram.sv
// Data array for one cache way: DATA_LEN slices, lowest-index read priority,
// one-cycle registered read. No handshake: an access is accepted every cycle.
module cache_bank_ram
  import cache_bank_ram_pkg::*;
#(
  parameter int DATA_LEN   = CB_DATA_LEN,
  parameter int DATA_PACK  = CB_DATA_PACK,
  parameter int DATA_WIDTH = CB_DATA_WIDTH,
  parameter int DATA_NUM   = CB_DATA_NUM,
  parameter int ADDR_WIDTH = CB_ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            srst_n,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [DATA_PACK*DATA_WIDTH-1:0] wdata,
  input  logic [DATA_LEN-1:0]             ren,
  input  logic [DATA_LEN-1:0]             wen,
  output logic [DATA_PACK*DATA_WIDTH-1:0] rdata
);

  localparam int W     = DATA_PACK * DATA_WIDTH;
  localparam int SEL_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

  logic [DATA_LEN-1:0] w_wen;
  logic [W-1:0]        w_slice_rd [DATA_LEN];
  logic [31:0]         w_ren_ext;
  logic [SEL_W-1:0]    w_sel;
  logic [W-1:0]        r_rdata;

  // Reset suppresses writes on the same edge.
  assign w_wen     = wen & {DATA_LEN{srst_n}};
  assign w_ren_ext = 32'(ren);
  assign w_sel     = SEL_W'(lowest_set(w_ren_ext));

  for (genvar g = 0; g < DATA_LEN; g++) begin : g_slice
    cache_bank_ram_slice #(
      .W          (W),
      .DATA_NUM   (DATA_NUM),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_slice (
      .clk     (clk),
      .i_we    (w_wen[g]),
      .i_addr  (addr),
      .i_wdata (wdata),
      .o_rdata (w_slice_rd[g])
    );
  end

  // Slices read the pre-edge contents, giving read-first collision behaviour.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_rdata <= '0;
    end else if (|ren) begin
      r_rdata <= w_slice_rd[w_sel];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: tb/tb_cache_bank_ram.sv
// Directed bench for cache_bank_ram: vector table plus back-to-back sweep
// and an out-of-range check on a DATA_NUM=48 instance.
module tb_cache_bank_ram;

  logic        clk;
  logic        srst_n;
  logic [5:0]  addr;
  logic [63:0] wdata;
  logic [3:0]  ren;
  logic [3:0]  wen;
  logic [63:0] rdata;

  logic [5:0]  addr2;
  logic [63:0] wdata2;
  logic [3:0]  ren2;
  logic [3:0]  wen2;
  logic [63:0] rdata2;

  int checks;
  int errors;

  logic [63:0] exp_q [$];

  typedef struct {
    logic        rst_n;
    logic [5:0]  addr;
    logic [63:0] wdata;
    logic [3:0]  ren;
    logic [3:0]  wen;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [$];

  cache_bank_ram dut (
    .clk    (clk),
    .srst_n (srst_n),
    .addr   (addr),
    .wdata  (wdata),
    .ren    (ren),
    .wen    (wen),
    .rdata  (rdata)
  );

  cache_bank_ram #(.DATA_NUM(48), .ADDR_WIDTH(6)) dut48 (
    .clk    (clk),
    .srst_n (srst_n),
    .addr   (addr2),
    .wdata  (wdata2),
    .ren    (ren2),
    .wen    (wen2),
    .rdata  (rdata2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [5:0] a, input logic [63:0] d,
                              input logic [3:0] re, input logic [3:0] we, input logic [63:0] e);
    vec_t v;
    v.rst_n = r; v.addr = a; v.wdata = d; v.ren = re; v.wen = we; v.exp = e;
    return v;
  endfunction

  function automatic logic [63:0] pat(input int a, input int s);
    return {16'hBEEF, 8'(a), 8'(s), (32'(a * 4 + s) ^ 32'h5A5A_0000)};
  endfunction

  initial begin
    logic [63:0] base;
    logic [63:0] dead;
    logic [63:0] got;
    checks = 0;
    errors = 0;
    base = 64'h1111_1111_0000_0005;
    dead = 64'hDEAD_BEEF_CAFE_F00D;

    srst_n = 1'b0; addr = '0; wdata = '0; ren = '0; wen = '0;
    addr2 = '0; wdata2 = '0; ren2 = '0; wen2 = '0;

    // reset, then a reset cycle that tries to overwrite addr0
    vecs.push_back(mk(1'b0, 6'd0, 64'h0, 4'b0000, 4'b0000, 64'h0));
    vecs.push_back(mk(1'b1, 6'd0, 64'h55, 4'b0000, 4'b0001, 64'h0));
    vecs.push_back(mk(1'b0, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0001, 4'b1111, 64'h0));
    vecs.push_back(mk(1'b0, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0001, 4'b1111, 64'h0));
    vecs.push_back(mk(1'b1, 6'd0, 64'h0, 4'b0001, 4'b0000, 64'h55));
    // fill addr 5 and read back, then hold
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1'b1, 6'd5, base + 64'(k), 4'b0000, 4'(1 << k), 64'h55));
    vecs.push_back(mk(1'b1, 6'd5, 64'h0, 4'b0100, 4'b0000, base + 64'd2));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1'b1, 6'd9, 64'h0, 4'b0000, 4'b0000, base + 64'd2));
    // read-first collision
    vecs.push_back(mk(1'b1, 6'd3, 64'hA, 4'b0000, 4'b0010, base + 64'd2));
    vecs.push_back(mk(1'b1, 6'd3, 64'hB, 4'b0010, 4'b0010, 64'hA));
    vecs.push_back(mk(1'b1, 6'd3, 64'h0, 4'b0010, 4'b0000, 64'hB));
    // multi-hot write and fixed-priority read
    vecs.push_back(mk(1'b1, 6'd63, dead, 4'b0000, 4'b1111, 64'hB));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1'b1, 6'd63, 64'h0, 4'(1 << k), 4'b0000, dead));
    vecs.push_back(mk(1'b1, 6'd5, 64'h0, 4'b1100, 4'b0000, base + 64'd2));
    vecs.push_back(mk(1'b1, 6'd5, 64'h0, 4'b1111, 4'b0000, base));
    // read and write of different sub-blocks in one cycle
    vecs.push_back(mk(1'b1, 6'd5, 64'hC, 4'b0001, 4'b0010, base));
    vecs.push_back(mk(1'b1, 6'd5, 64'h0, 4'b0010, 4'b0000, 64'hC));

    for (int i = 0; i < vecs.size(); i++) begin
      srst_n = vecs[i].rst_n; addr = vecs[i].addr; wdata = vecs[i].wdata;
      ren = vecs[i].ren; wen = vecs[i].wen;
      tick();
      check($sformatf("vec%0d", i), rdata, vecs[i].exp);
    end
    ren = '0; wen = '0;

    // back-to-back sweep after a unique-pattern fill
    for (int a = 0; a < 64; a++)
      for (int s = 0; s < 4; s++) begin
        addr = 6'(a); wdata = pat(a, s); wen = 4'(1 << s);
        tick();
      end
    wen = '0;
    for (int a = 0; a < 64; a++)
      for (int s = 0; s < 4; s++) begin
        addr = 6'(a); ren = 4'(1 << s);
        exp_q.push_back(pat(a, s));
        tick();
        got = exp_q.pop_front();
        check($sformatf("b2b a%0d s%0d", a, s), rdata, got);
      end
    ren = '0;

    // out-of-range on the 48-set instance
    addr2 = 6'd2; wdata2 = 64'h2222; wen2 = 4'b0001;
    tick();
    wen2 = '0; ren2 = 4'b0001;
    tick();
    check("oor prime addr2", rdata2, 64'h2222);
    addr2 = 6'd50; wdata2 = 64'h5050; wen2 = 4'b0001; ren2 = '0;
    tick();
    check("oor hold", rdata2, 64'h2222);
    wen2 = '0; ren2 = 4'b0001;
    tick();
    check("oor read addr50", rdata2, 64'h0);
    addr2 = 6'd2;
    tick();
    check("oor no alias addr2", rdata2, 64'h2222);
    ren2 = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
